i2c_slave_fifo: RTL and testbench

//  I2C target (slave) responding at one fixed 7-bit address; counterpart to the team's FIFO-buffered I2C master.

---
 rtl/i2c_slave_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_fifo.sv
// I2C target (slave) at one fixed 7-bit address, with byte FIFOs on both directions.
// Bytes written by the bus master are pushed into an RX FIFO. Bytes read by the bus
// master are taken from a TX FIFO that local logic fills.
// SCL and SDA are oversampled on clk. The target never stretches the clock. SDA is
// open-drain: the target drives it to 0 or leaves it at z.
//
// Ports
//   clk          system clock; all logic runs on its rising edge
//   reset        synchronous reset, active low
//   wr           push w_fifo_data into the TX FIFO (ignored when full_tx)
//   rd           pop the RX FIFO head (ignored when empty_rx)
//   w_fifo_data  byte to send on a master read
//   r_fifo_data  RX FIFO head, first-word fall-through; valid when !empty_rx
//   empty_tx     TX FIFO empty
//   full_tx      TX FIFO full
//   empty_rx     RX FIFO empty
//   full_rx      RX FIFO full
//   busy         high from address match until STOP, address mismatch or master NACK
//   scl          I2C clock from the master
//   sda          I2C data, open-drain
module i2c_slave_fifo #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h15,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] w_fifo_data,
  output logic [7:0] r_fifo_data,
  output logic       empty_tx,
  output logic       full_tx,
  output logic       empty_rx,
  output logic       full_rx,
  output logic       busy,
  input  logic       scl,
  inout  wire        sda
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrite,
    StDataAck,
    StRead,
    StReadAck,
    StWaitStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Bus sampling: 2-flop synchroniser plus one history flop per line
  // ---------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // The lines idle high, so the sampling flops reset to 1. A false START is
  // therefore not seen on the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [7:0]            tx_mem [Depth];
  logic [ADDR_WIDTH-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
  logic                  tx_empty_q, tx_full_q;
  logic                  tx_pop, tx_do_push, tx_do_pop;

  logic [7:0]            rx_mem [Depth];
  logic [ADDR_WIDTH-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
  logic                  rx_empty_q, rx_full_q;
  logic                  rx_push, rx_do_push, rx_do_pop;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;        // bytes received from the master
  logic [6:0] tx_shift_q, tx_shift_d;  // bits still to send; the MSB goes straight to sda
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] tx_load_byte;

  // Byte for the next master read. An empty TX FIFO yields all ones, which
  // leaves the bus released.
  assign tx_load_byte = tx_empty_q ? 8'hFF : tx_mem[tx_rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    rx_push    = 1'b0;
    tx_pop     = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              // shift_q[6:0] holds address bits 7..1; the bit now on sda is R/W.
              if (shift_q[6:0] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
                rw_d    = sda_s2_q;
              end else begin
                state_d = StIdle;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // bit_cnt 0: waiting for the fall that opens the ACK slot.
        // bit_cnt 1: waiting for the fall that closes it.
        StAddrAck: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 3'd1;
            end else begin
              bit_cnt_d = '0;
              if (rw_q) begin
                state_d    = StRead;
                tx_pop     = 1'b1;
                tx_shift_d = tx_load_byte[6:0];
                sda_oe_d   = ~tx_load_byte[7];
              end else begin
                state_d  = StWrite;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        StWrite: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d   = StDataAck;
              bit_cnt_d = '0;
            end
          end
        end
        StDataAck: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d = 3'd1;
              // A full RX FIFO drops the byte and NACKs it by leaving sda released.
              if (!rx_full_q) begin
                rx_push  = 1'b1;
                sda_oe_d = 1'b1;
              end else begin
                sda_oe_d = 1'b0;
              end
            end else begin
              state_d   = StWrite;
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
            end
          end
        end
        StRead: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = StReadAck;
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
            end else begin
              bit_cnt_d  = bit_cnt_q + 3'd1;
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b1};
            end
          end
        end
        StReadAck: begin
          if (scl_rise) begin
            if (sda_s2_q) begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            // Reaching this fall means the rise before it saw an ACK.
            state_d    = StRead;
            tx_pop     = 1'b1;
            tx_shift_d = tx_load_byte[6:0];
            sda_oe_d   = ~tx_load_byte[7];
          end
        end
        StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign busy = busy_q;

  // ---------------------------------------------------------------------------
  // TX FIFO: filled by local logic, emptied by master reads
  // ---------------------------------------------------------------------------
  assign tx_do_push = wr & ~tx_full_q;
  assign tx_do_pop  = tx_pop & ~tx_empty_q;
  assign tx_cnt_d   = tx_cnt_q + CntW'(tx_do_push) - CntW'(tx_do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      tx_empty_q  <= 1'b1;
      tx_full_q   <= 1'b0;
    end else begin
      if (tx_do_push) tx_wr_ptr_q <= tx_wr_ptr_q + ADDR_WIDTH'(1);
      if (tx_do_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + ADDR_WIDTH'(1);
      tx_cnt_q   <= tx_cnt_d;
      tx_empty_q <= (tx_cnt_d == '0);
      tx_full_q  <= (tx_cnt_d == CntW'(Depth));
    end
  end

  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wr_ptr_q] <= w_fifo_data;
  end

  assign empty_tx = tx_empty_q;
  assign full_tx  = tx_full_q;

  // ---------------------------------------------------------------------------
  // RX FIFO: filled by master writes, drained by local logic
  // ---------------------------------------------------------------------------
  assign rx_do_push = rx_push & ~rx_full_q;
  assign rx_do_pop  = rd & ~rx_empty_q;
  assign rx_cnt_d   = rx_cnt_q + CntW'(rx_do_push) - CntW'(rx_do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_empty_q  <= 1'b1;
      rx_full_q   <= 1'b0;
    end else begin
      if (rx_do_push) rx_wr_ptr_q <= rx_wr_ptr_q + ADDR_WIDTH'(1);
      if (rx_do_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + ADDR_WIDTH'(1);
      rx_cnt_q   <= rx_cnt_d;
      rx_empty_q <= (rx_cnt_d == '0);
      rx_full_q  <= (rx_cnt_d == CntW'(Depth));
    end
  end

  always_ff @(posedge clk) begin
    if (rx_do_push) rx_mem[rx_wr_ptr_q] <= shift_q;
  end

  assign r_fifo_data = rx_mem[rx_rd_ptr_q];
  assign empty_rx    = rx_empty_q;
  assign full_rx     = rx_full_q;

endmodule

// File: tb/tb_i2c_slave_fifo.sv
// Self-checking bench for i2c_slave_fifo. A bit-banged I2C master drives the bus.
// Expected results come from a queue model of the two FIFOs, from a vector table,
// and from directed sequences.
module tb_i2c_slave_fifo;

  localparam int H     = 80;  // SCL phase length in ns (8 clk)
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       reset, wr, rd, scl, m_sda;
  logic [7:0] w_fifo_data;
  wire  [7:0] r_fifo_data;
  wire        empty_tx, full_tx, empty_rx, full_rx, busy;
  wire        sda;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_fifo #(
    .SLAVE_ADDR(7'h15),
    .ADDR_WIDTH(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .rd         (rd),
    .w_fifo_data(w_fifo_data),
    .r_fifo_data(r_fifo_data),
    .empty_tx   (empty_tx),
    .full_tx    (full_tx),
    .empty_rx   (empty_rx),
    .full_rx    (full_rx),
    .busy       (busy),
    .scl        (scl),
    .sda        (sda)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the contents of each FIFO as plain queues.
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  logic [7:0] wq[$];  // bytes for the next master write

  typedef struct {
    logic [7:0] din;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_flags();
    chk("empty_tx", empty_tx, tx_m.size() == 0);
    chk("full_tx", full_tx, tx_m.size() == Depth);
    chk("empty_rx", empty_rx, rx_m.size() == 0);
    chk("full_rx", full_rx, rx_m.size() == Depth);
  endtask

  task automatic local_wr(input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1;
    w_fifo_data = d;
    @(negedge clk);
    wr = 1'b0;
    if (tx_m.size() < Depth) tx_m.push_back(d);
  endtask

  task automatic local_rd();
    @(negedge clk);
    if (rx_m.size() > 0) chk("rx_head", r_fifo_data, rx_m[0]);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (rx_m.size() > 0) void'(rx_m.pop_front());
  endtask

  // Bit-level master. Each bit starts and ends with scl low.
  task automatic bit_w(input logic b);
    m_sda = b;
    #H scl = 1'b1;
    #H scl = 1'b0;
  endtask

  task automatic bit_r(output logic b);
    m_sda = 1'b1;
    #H scl = 1'b1;
    #(H/2) b = sda;
    #(H/2) scl = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    #H scl = 1'b1;
    #H m_sda = 1'b0;
    #H scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #H scl = 1'b1;
    #H m_sda = 1'b1;
    #H;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) bit_w(b[i]);
    bit_r(a);
    ack = ~a;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      bit_r(x);
      b[i] = x;
    end
    bit_w(~mack);
  endtask

  // Full master-write transaction of the bytes in wq.
  task automatic xfer_write(input logic [6:0] addr);
    logic ack, match, exp;
    match = (addr == 7'h15);
    i2c_start();
    send_byte({addr, 1'b0}, ack);
    chk("addr_ack_w", ack, match);
    chk("busy_w", busy, match);
    foreach (wq[i]) begin
      send_byte(wq[i], ack);
      exp = match && (rx_m.size() < Depth);
      if (exp) rx_m.push_back(wq[i]);
      chk("data_ack", ack, exp);
    end
    i2c_stop();
    chk("busy_after_stop", busy, 1'b0);
    chk_flags();
    wq.delete();
  endtask

  // Full master-read transaction of n bytes: ACK on all but the last.
  task automatic xfer_read(input int n);
    logic ack;
    logic [7:0] b, exp;
    i2c_start();
    send_byte({7'h15, 1'b1}, ack);
    chk("addr_ack_r", ack, 1'b1);
    chk("busy_r", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i != n - 1);
      exp = (tx_m.size() > 0) ? tx_m.pop_front() : 8'hFF;
      chk("rd_byte", b, exp);
    end
    chk("busy_after_nack", busy, 1'b0);
    i2c_stop();
    chk_flags();
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack;
    logic [7:0] b;
    logic [6:0] a;

    tbl[0] = '{8'h56, 1'b0, 1'b0, 8'h56};
    tbl[1] = '{8'h37, 1'b0, 1'b0, 8'h37};
    tbl[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5};
    tbl[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C};
    tbl[4] = '{8'h77, 1'b0, 1'b1, 8'hFF};  // pushed into a full FIFO: dropped

    reset = 1'b0; wr = 1'b0; rd = 1'b0; w_fifo_data = '0; scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda, 1'b1);
    chk_flags();

    // Test 1: write two bytes, then drain them.
    wq = '{8'hAA, 8'hBB};
    xfer_write(7'h15);
    local_rd();
    local_rd();
    chk_flags();

    // TX fill from the vector table, then read everything back over the bus.
    for (int i = 0; i < 5; i++) begin
      local_wr(tbl[i].din);
      chk("tbl_empty_tx", empty_tx, tbl[i].exp_empty);
      chk("tbl_full_tx", full_tx, tbl[i].exp_full);
    end
    i2c_start();
    send_byte({7'h15, 1'b1}, ack);
    chk("tbl_addr_ack", ack, 1'b1);
    for (int i = 0; i < 5; i++) begin
      recv_byte(b, i < 4);
      chk("tbl_rd", b, tbl[i].exp_rd);
    end
    i2c_stop();
    tx_m.delete();
    chk_flags();

    // Test 2: read two bytes; a third read in a new transaction sees an empty FIFO.
    local_wr(8'h56);
    local_wr(8'h37);
    xfer_read(2);
    xfer_read(1);

    // Test 3: address mismatch leaves the bus and the FIFOs untouched.
    wq = '{8'h5E};
    xfer_write(7'h16);

    // Test 4: RX overflow. The fifth byte is NACKed and dropped.
    wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    xfer_write(7'h15);
    for (int i = 0; i < 4; i++) local_rd();
    chk_flags();

    // Test 5: repeated START switches from write to read.
    local_wr(8'h99);
    i2c_start();
    send_byte(8'h2A, ack);
    chk("sr_addr_w", ack, 1'b1);
    send_byte(8'h11, ack);
    chk("sr_data_ack", ack, 1'b1);
    rx_m.push_back(8'h11);
    i2c_start();
    send_byte(8'h2B, ack);
    chk("sr_addr_r", ack, 1'b1);
    recv_byte(b, 1'b0);
    chk("sr_rd", b, 8'h99);
    void'(tx_m.pop_front());
    i2c_stop();
    chk_flags();
    local_rd();

    // Test 6: reset in the middle of a read aborts it and clears both FIFOs.
    wq = '{8'h42};
    xfer_write(7'h15);
    local_wr(8'h00);
    local_wr(8'h5A);
    i2c_start();
    send_byte(8'h2B, ack);
    for (int i = 0; i < 4; i++) bit_r(ack);
    #30;
    chk("pre_rst_drive", sda, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tx_m.delete();
    rx_m.delete();
    chk("mid_rst_sda", sda, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk_flags();
    wq = '{8'h3C};
    xfer_write(7'h15);
    local_rd();

    // Randomised mix of local FIFO operations and bus transactions.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin local_wr(8'($urandom)); chk_flags(); end
        1: begin local_rd(); chk_flags(); end
        2: begin
          for (int k = $urandom_range(1, 3); k > 0; k--) wq.push_back(8'($urandom));
          xfer_write(7'h15);
        end
        3: xfer_read($urandom_range(1, 3));
        default: begin
          a = 7'($urandom);
          if (a == 7'h15) a = a ^ 7'h01;
          wq.push_back(8'($urandom));
          xfer_write(a);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
